ser_shift_unit: RTL and testbench

- Parametrised parallel-to-serial converter; next generation of the UART TX serialiser.
- Adds configurable word width, selectable bit order, a one-entry holding buffer with a ready/valid input handshake, back-to-back words with no idle gap, and a parity output for the TX parity stage.
- Sits between the TX data source and the TX frame FSM/output mux.
- The frame FSM paces bit emission with ser_en.

---
 rtl/ser_pkg.sv | 26 ++
 rtl/ser_hold_buf.sv | 49 ++++
 rtl/ser_shift_unit.sv | 123 ++++++++++++
 tb/tb_ser_shift_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and elaboration helpers for the serial shift unit.
package ser_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } ser_state_e;

    localparam int unsigned DataWMin = 2;
    localparam int unsigned DataWMax = 32;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit data_w_legal(input int unsigned width);
        return (width >= DataWMin) && (width <= DataWMax);
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer in front of the shifter, with ready/valid accept.
module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] p_data,
    input  logic              drain,
    output logic              data_ready,
    output logic              hold_full,
    output logic [DATA_W-1:0] hold_data
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;

    // Ready comes straight from the flop: no combinational path from data_valid.
    assign data_ready = !full_q;
    assign hold_full  = full_q;
    assign hold_data  = data_q;
    assign accept     = data_valid && !full_q;

    // Accept needs an empty slot and drain needs a full one, so they never collide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = p_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rest) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ser_shift_unit.sv
// Parallel-to-serial converter for the UART TX path: holding buffer, shifter,
// bit counter and parity, paced by ser_en from the frame FSM.
module ser_shift_unit
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          PAR_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] p_data,
    output logic              data_ready,
    input  logic              ser_en,
    output logic              ser_data,
    output logic              ser_done,
    output logic              par_bit,
    output logic              busy
);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("ser_shift_unit: DATA_W must be within 2..32");
    end

    localparam int unsigned      CntW    = clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shifter_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   bit_idx;
    logic              ser_data_q;
    logic              par_q;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic              load;
    logic              shift;
    logic              last_bit;

    ser_hold_buf #(
        .DATA_W(DATA_W)
    ) u_hold_buf (
        .clk       (clk),
        .rest      (rest),
        .data_valid(data_valid),
        .p_data    (p_data),
        .drain     (load),
        .data_ready(data_ready),
        .hold_full (hold_full),
        .hold_data (hold_data)
    );

    assign last_bit = (cnt_q == CntLast);
    assign bit_idx  = MSB_FIRST ? (CntLast - cnt_q) : cnt_q;

    always_ff @(posedge clk) begin
        if (!rest) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (hold_full) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (ser_en && last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Reloading straight from DONE keeps words back-to-back.
                state_d = hold_full ? StShift : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        shift    = 1'b0;
        ser_done = 1'b0;
        unique case (state_q)
            StIdle:  load = hold_full;
            StShift: shift = ser_en;
            StDone: begin
                ser_done = 1'b1;
                load     = hold_full;
            end
            default: ;
        endcase
        busy = (state_q != StIdle) || hold_full;
    end

    always_ff @(posedge clk) begin
        if (!rest) begin
            shifter_q  <= '0;
            cnt_q      <= '0;
            ser_data_q <= 1'b0;
            par_q      <= 1'b0;
        end else if (load) begin
            shifter_q <= hold_data;
            cnt_q     <= '0;
            par_q     <= (^hold_data) ^ PAR_ODD;
        end else if (shift) begin
            ser_data_q <= shifter_q[bit_idx];
            if (!last_bit) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign ser_data = ser_data_q;
    assign par_bit  = par_q;

endmodule

// File: tb/tb_ser_shift_unit.sv
// Directed bench for ser_shift_unit: an 8-bit LSB-first/even instance and a
// 12-bit MSB-first/odd instance driven from hand-computed vectors.
module tb_ser_shift_unit;

    logic        clk;
    logic        rest;

    logic        valid8, en8, ready8, sdata8, done8, par8, busy8;
    logic [7:0]  pdata8;
    logic        valid12, en12, ready12, sdata12, done12, par12, busy12;
    logic [11:0] pdata12;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;   // emitted bits, leftmost first
        logic       par;
    } vec_t;

    vec_t vecs[6];

    ser_shift_unit #(
        .DATA_W   (8),
        .MSB_FIRST(1'b0),
        .PAR_ODD  (1'b0)
    ) dut8 (
        .clk       (clk),
        .rest      (rest),
        .data_valid(valid8),
        .p_data    (pdata8),
        .data_ready(ready8),
        .ser_en    (en8),
        .ser_data  (sdata8),
        .ser_done  (done8),
        .par_bit   (par8),
        .busy      (busy8)
    );

    ser_shift_unit #(
        .DATA_W   (12),
        .MSB_FIRST(1'b1),
        .PAR_ODD  (1'b1)
    ) dut12 (
        .clk       (clk),
        .rest      (rest),
        .data_valid(valid12),
        .p_data    (pdata12),
        .data_ready(ready12),
        .ser_en    (en12),
        .ser_data  (sdata12),
        .ser_done  (done12),
        .par_bit   (par12),
        .busy      (busy12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [11:0] seq12;
    logic [7:0]  seq3c;
    logic        prev;
    logic        exp_d;
    logic        exp_done;
    logic        exp_busy;
    logic        exp_rdy;

    initial begin
        checks  = 0;
        errors  = 0;
        rest    = 1'b0;
        valid8  = 1'b0; en8  = 1'b0; pdata8  = '0;
        valid12 = 1'b0; en12 = 1'b0; pdata12 = '0;

        vecs[0] = '{data: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
        vecs[1] = '{data: 8'h3C, seq: 8'b0011_1100, par: 1'b0};
        vecs[2] = '{data: 8'h01, seq: 8'b1000_0000, par: 1'b1};
        vecs[3] = '{data: 8'h80, seq: 8'b0000_0001, par: 1'b1};
        vecs[4] = '{data: 8'h6B, seq: 8'b1101_0110, par: 1'b1};
        vecs[5] = '{data: 8'hFF, seq: 8'b1111_1111, par: 1'b0};

        // Power-on reset
        tick();
        tick();
        rest = 1'b1;
        chk("rst ser_data", 32'(sdata8), 32'd0);
        chk("rst ser_done", 32'(done8), 32'd0);
        chk("rst par_bit", 32'(par8), 32'd0);
        chk("rst busy", 32'(busy8), 32'd0);
        chk("rst data_ready", 32'(ready8), 32'd1);
        chk("rst12 busy", 32'(busy12), 32'd0);
        chk("rst12 data_ready", 32'(ready12), 32'd1);

        // Table-driven words, ser_en held high
        en8 = 1'b1;
        for (int v = 0; v < 6; v++) begin
            chk($sformatf("v%0d ready before", v), 32'(ready8), 32'd1);
            valid8 = 1'b1;
            pdata8 = vecs[v].data;
            tick();
            valid8 = 1'b0;
            tick();
            chk($sformatf("v%0d par_bit", v), 32'(par8), 32'(vecs[v].par));
            for (int i = 0; i < 8; i++) begin
                tick();
                chk($sformatf("v%0d bit%0d", v, i), 32'(sdata8), 32'(vecs[v].seq[7-i]));
                chk($sformatf("v%0d done@%0d", v, i), 32'(done8), (i == 7) ? 32'd1 : 32'd0);
            end
            tick();
            chk($sformatf("v%0d done end", v), 32'(done8), 32'd0);
            chk($sformatf("v%0d busy end", v), 32'(busy8), 32'd0);
        end

        // 12-bit MSB-first odd parity: 12'h801
        seq12   = 12'b1000_0000_0001;
        en12    = 1'b1;
        valid12 = 1'b1;
        pdata12 = 12'h801;
        tick();
        valid12 = 1'b0;
        tick();
        chk("w12 par_bit", 32'(par12), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("w12 bit%0d", i), 32'(sdata12), 32'(seq12[11-i]));
            chk($sformatf("w12 done@%0d", i), 32'(done12), (i == 11) ? 32'd1 : 32'd0);
        end
        tick();
        chk("w12 done end", 32'(done12), 32'd0);
        chk("w12 busy end", 32'(busy12), 32'd0);

        // ser_en pattern 1,0,0 during 8'h3C: bits hold while disabled
        seq3c  = 8'b0011_1100;
        en8    = 1'b0;
        valid8 = 1'b1;
        pdata8 = 8'h3C;
        tick();
        valid8 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            en8 = 1'b1;
            tick();
            chk($sformatf("gate bit%0d", i), 32'(sdata8), 32'(seq3c[7-i]));
            chk($sformatf("gate done@%0d", i), 32'(done8), (i == 7) ? 32'd1 : 32'd0);
            prev = sdata8;
            en8  = 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick();
                chk($sformatf("gate hold%0d.%0d", i, j), 32'(sdata8), 32'(prev));
                if (i < 7) begin
                    chk($sformatf("gate nodone%0d.%0d", i, j), 32'(done8), 32'd0);
                end
            end
        end
        chk("gate idle", 32'(busy8), 32'd0);

        // Back-to-back FF then 00; third word offered while not ready is dropped.
        // Cycle k counts edges after the accept of 8'hFF.
        en8    = 1'b1;
        valid8 = 1'b1;
        pdata8 = 8'hFF;
        tick();
        pdata8 = 8'h00;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 2) pdata8 = 8'h5A;
            if (k == 5) valid8 = 1'b0;
            exp_d    = (k >= 2 && k <= 10) ? 1'b1 : 1'b0;
            exp_done = (k == 9 || k == 18) ? 1'b1 : 1'b0;
            exp_busy = (k <= 18) ? 1'b1 : 1'b0;
            exp_rdy  = (k >= 2 && k <= 9) ? 1'b0 : 1'b1;
            if (k >= 2) begin
                chk($sformatf("b2b ser_data k%0d", k), 32'(sdata8), 32'(exp_d));
            end
            chk($sformatf("b2b done k%0d", k), 32'(done8), 32'(exp_done));
            chk($sformatf("b2b busy k%0d", k), 32'(busy8), 32'(exp_busy));
            chk($sformatf("b2b ready k%0d", k), 32'(ready8), 32'(exp_rdy));
        end

        // Reset mid-word with a second word buffered
        valid8 = 1'b1;
        pdata8 = 8'h3C;
        tick();
        pdata8 = 8'hA5;
        tick();
        tick();
        valid8 = 1'b0;
        tick();
        tick();
        tick();
        chk("mid busy", 32'(busy8), 32'd1);
        chk("mid ready", 32'(ready8), 32'd0);
        chk("mid ser_data", 32'(sdata8), 32'd1);
        rest = 1'b0;
        tick();
        tick();
        rest = 1'b1;
        chk("rst2 ser_data", 32'(sdata8), 32'd0);
        chk("rst2 ser_done", 32'(done8), 32'd0);
        chk("rst2 busy", 32'(busy8), 32'd0);
        chk("rst2 ready", 32'(ready8), 32'd1);
        chk("rst2 par_bit", 32'(par8), 32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rst2 quiet busy%0d", k), 32'(busy8), 32'd0);
            chk($sformatf("rst2 quiet data%0d", k), 32'(sdata8), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
